// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece type codes, rotation-0 shape bitmaps and
// the hold-controller state encoding.
package tetris_pkg;

  // Piece type codes; 7 means "no piece"
  localparam logic [2:0] PIECE_I   = 3'd0;
  localparam logic [2:0] PIECE_O   = 3'd1;
  localparam logic [2:0] PIECE_T   = 3'd2;
  localparam logic [2:0] PIECE_S   = 3'd3;
  localparam logic [2:0] PIECE_Z   = 3'd4;
  localparam logic [2:0] PIECE_J   = 3'd5;
  localparam logic [2:0] PIECE_L   = 3'd6;
  localparam logic [2:0] NONE_TYPE = 3'd7;

  // 4x4 bitmaps at rotation 0, indexed by piece type; bit i = row i/4, col i%4.
  // Packed concatenation lists index 7 (NONE) first, index 0 (I) last.
  localparam logic [7:0][15:0] SHAPE_ROT0 = {
    16'h0000,  // NONE
    16'h0074,  // L
    16'h0071,  // J
    16'h0063,  // Z
    16'h0036,  // S
    16'h0072,  // T
    16'h0066,  // O
    16'h00F0   // I
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REQ     = 2'd2
  } hold_state_t;

endpackage

// File: rtl/piece_shape_rom.sv
// Combinational piece type -> rotation-0 4x4 bitmap lookup.
// Also used by the next-piece preview renderer.
module piece_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]  i_type,
  output logic [15:0] o_square
);

  assign o_square = SHAPE_ROT0[i_type];

endmodule

// File: rtl/hold_piece_ctrl_module.sv
// Tetris hold-feature sequencer: captures the falling piece on a hold key
// press, asks the game FSM to swap in the previously held piece (or the next
// queued piece), allows one hold per spawned piece, and publishes the held
// piece bitmap to the VGA hold box on frame boundaries only.
module hold_piece_ctrl_module
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_clr,
  input  logic        hold_key,
  input  logic        cur_valid,
  input  logic [2:0]  cur_type,
  input  logic        piece_spawn,
  input  logic        frame_start,
  output logic        swap_req,
  output logic        swap_from_q,
  output logic [2:0]  swap_type,
  input  logic        swap_ack,
  output logic        hold_valid,
  output logic        hold_used,
  output logic [15:0] hold_square,
  output logic        busy
);

  hold_state_t r_state;
  hold_state_t w_next_state;
  logic        r_key_s;
  logic        r_key_d;
  logic        w_press;
  logic [2:0]  r_held;
  logic [2:0]  r_old_held;
  logic        r_hold_valid;
  logic        r_hold_used;
  logic [15:0] r_hold_square;
  logic [15:0] w_held_shape;

  // Register the key and keep one delayed copy for rising-edge detection
  // NOTE: both stages reset to 1 so a key already down when reset releases
  // is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s <= 1'b1;
      r_key_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let r_key_d see the old r_key_s.
      r_key_s <= hold_key;
      r_key_d <= r_key_s;
    end
  end

  assign w_press = r_key_s & ~r_key_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic; game_clr overrides everything
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    if (game_clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        // A spawn in the same cycle re-arms hold before the press is judged
        ST_IDLE:    if (w_press && cur_valid && (!r_hold_used || piece_spawn))
                      w_next_state = ST_CAPTURE;
        ST_CAPTURE: w_next_state = ST_REQ;
        ST_REQ:     if (swap_ack) w_next_state = ST_IDLE;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; the swap request is held steady for the whole REQ state
  always_comb begin
    swap_req    = 1'b0;
    swap_from_q = 1'b0;
    swap_type   = 3'd0;
    busy        = (r_state != ST_IDLE);
    if (r_state == ST_REQ) begin
      swap_req    = 1'b1;
      swap_from_q = (r_old_held == NONE_TYPE);
      swap_type   = (r_old_held == NONE_TYPE) ? 3'd0 : r_old_held;
    end
  end

  // Held piece bookkeeping and the one-hold-per-piece flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held       <= NONE_TYPE;
      r_old_held   <= NONE_TYPE;
      r_hold_valid <= 1'b0;
      r_hold_used  <= 1'b0;
    end else if (game_clr) begin
      r_held       <= NONE_TYPE;
      r_hold_valid <= 1'b0;
      r_hold_used  <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      r_old_held   <= r_held;
      r_held       <= cur_type;
      r_hold_valid <= 1'b1;
      r_hold_used  <= 1'b1;
    end else if (piece_spawn && (r_state == ST_IDLE)) begin
      // Spawns during CAPTURE/REQ come from our own swap and must not re-arm
      r_hold_used  <= 1'b0;
    end
  end

  piece_shape_rom u_shape_rom (
    .i_type   (r_held),
    .o_square (w_held_shape)
  );

  // Hold-box bitmap updates only at frame start to avoid mid-frame tearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_hold_square <= 16'h0000;
    else if (frame_start) r_hold_square <= w_held_shape;
  end

  assign hold_valid  = r_hold_valid;
  assign hold_used   = r_hold_used;
  assign hold_square = r_hold_square;

endmodule
